echo_effect: RTL and testbench

- Post-mix audio effect stage. It sits directly downstream of the music player and consumes its 16-bit signed sample stream and per-sample strobe.
- It adds a decaying feedback echo using a circular delay-line RAM.
- It drives the processed sample and strobe onward to the codec path.
- When disabled it passes samples through dry, while still recording them into the delay line.

---
 rtl/echo_effect.sv | 186 ++++++++++++++++++
 tb/tb_echo_effect.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_effect.sv
// echo_effect: post-mix feedback echo stage between the music player and the codec.
// Each accepted sample is mixed with an attenuated copy of an earlier output read
// from a circular delay line. The mix is written back into the delay line, so the
// echo repeats and decays. When echo is disabled the sample passes through dry but
// is still recorded into the delay line.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   sample_in         - signed input sample, qualified by sample_valid (one-cycle strobe)
//   echo_en           - 1 = add echo, 0 = dry pass-through (sampled at capture)
//   delay             - echo delay in samples, 0 means DEPTH (sampled at capture)
//   decay_shift       - echo = delayed sample >>> (decay_shift+1) (sampled at capture)
//   sample_out        - processed sample, holds between strobes
//   sample_out_valid  - one-cycle strobe when sample_out updates
//   busy              - high while the delay line is being cleared
//   drop              - sticky: an input sample was discarded
module echo_effect #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [WIDTH-1:0]  sample_in,
    input  logic                     sample_valid,
    input  logic                     echo_en,
    input  logic [ADDR_W-1:0]        delay,
    input  logic [1:0]               decay_shift,
    output logic signed [WIDTH-1:0]  sample_out,
    output logic                     sample_out_valid,
    output logic                     busy,
    output logic                     drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_MIX} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic signed [WIDTH-1:0]   smp_q, smp_d;
    logic                      en_q, en_d;
    logic [1:0]                dshift_q, dshift_d;
    logic signed [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic signed [WIDTH-1:0]   sample_out_q, sample_out_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      drop_q, drop_d;

    // Delay-line RAM and its registered read port
    logic signed [WIDTH-1:0]   mem [DEPTH];
    logic signed [WIDTH-1:0]   ram_rd_q;
    logic                      ram_we_c;
    logic                      ram_re_c;
    logic [ADDR_W-1:0]         ram_waddr_c;
    logic [ADDR_W-1:0]         ram_raddr_c;
    logic signed [WIDTH-1:0]   ram_wdata_c;

    logic signed [WIDTH-1:0]   echo_c;
    logic        [WIDTH:0]     sum_c;
    logic signed [WIDTH-1:0]   mix_c;

    // Attenuated echo, one-bit-extended sum, and saturating mix
    always_comb begin
        echo_c = rd_data_q >>> (3'(dshift_q) + 3'd1);
        sum_c  = {smp_q[WIDTH-1], smp_q} + {echo_c[WIDTH-1], echo_c};
        mix_c  = smp_q;
        if (en_q) begin
            if (sum_c[WIDTH] != sum_c[WIDTH-1]) begin
                mix_c = sum_c[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                mix_c = sum_c[WIDTH-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = S_IDLE;
            S_IDLE:  if (sample_valid) state_d = S_RD;
            S_RD:    state_d = S_MIX;
            S_MIX:   state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        smp_d        = smp_q;
        en_d         = en_q;
        dshift_d     = dshift_q;
        rd_data_d    = rd_data_q;
        sample_out_d = sample_out_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        drop_d       = drop_q;
        ram_we_c     = 1'b0;
        ram_re_c     = 1'b0;
        ram_waddr_c  = wr_ptr_q;
        ram_wdata_c  = mix_c;
        // Read address uses the live delay: it is presented in the capture cycle
        ram_raddr_c  = wr_ptr_q - delay;
        case (state_q)
            S_CLEAR: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_cnt_q;
                ram_wdata_c = '0;
                clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) busy_d = 1'b0;
                if (sample_valid) drop_d = 1'b1;
            end
            S_IDLE: begin
                if (sample_valid) begin
                    smp_d    = sample_in;
                    en_d     = echo_en;
                    dshift_d = decay_shift;
                    ram_re_c = 1'b1;
                end
            end
            S_RD: begin
                rd_data_d = ram_rd_q;
                if (sample_valid) drop_d = 1'b1;
            end
            S_MIX: begin
                sample_out_d = mix_c;
                valid_d      = 1'b1;
                ram_we_c     = 1'b1;
                wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                if (sample_valid) drop_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            smp_q        <= '0;
            en_q         <= 1'b0;
            dshift_q     <= '0;
            rd_data_q    <= '0;
            sample_out_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b1;
            drop_q       <= 1'b0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            smp_q        <= smp_d;
            en_q         <= en_d;
            dshift_q     <= dshift_d;
            rd_data_q    <= rd_data_d;
            sample_out_q <= sample_out_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    // Delay-line RAM: one write port, one synchronous read port
    always_ff @(posedge clk) begin
        if (ram_we_c) mem[ram_waddr_c] <= ram_wdata_c;
        if (ram_re_c) ram_rd_q <= mem[ram_raddr_c];
    end

    assign sample_out       = sample_out_q;
    assign sample_out_valid = valid_q;
    assign busy             = busy_q;
    assign drop             = drop_q;

endmodule

// File: tb/tb_echo_effect.sv
// Testbench for echo_effect (ADDR_W=4, DEPTH=16). A sample-level model computes
// echoes with integer floor division and explicit clamping.
module tb_echo_effect;

    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               echo_en;
    logic [3:0]         delay;
    logic [1:0]         decay_shift;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic               busy;
    logic               drop;

    echo_effect #(.ADDR_W(4), .WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .echo_en          (echo_en),
        .delay            (delay),
        .decay_shift      (decay_shift),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .drop             (drop)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int obs_q[$];
    int exp_q[$];

    // Reference model state
    int mem_m[DEPTH];
    int m_wr;
    int cool;
    int m_clr;
    bit m_drop;

    always @(negedge clk) begin
        if (!reset && sample_out_valid) obs_q.push_back(int'(sample_out));
    end

    function automatic int fdiv(input int a, input int p);
        if (a >= 0) return a / p;
        return -((-a + p - 1) / p);
    endfunction

    // One accepted sample: echo from 'dly' outputs ago (0 means DEPTH), saturated
    function automatic int model_mix(input int x, input bit en, input int dly, input int ds);
        int d;
        int s;
        d = (dly == 0) ? DEPTH : dly;
        s = x;
        if (en) s = x + fdiv(mem_m[(m_wr - d + 2 * DEPTH) % DEPTH], 2 ** (ds + 1));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        mem_m[m_wr] = s;
        m_wr = (m_wr + 1) % DEPTH;
        return s;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        m_wr = 0;
        cool = 0;
        m_clr = DEPTH;
        m_drop = 1'b0;
    endfunction

    // Drive one cycle (called #1 after a rising edge) and advance the model
    task automatic tick(input bit v, input int x, input bit en, input int dly, input int ds);
        sample_valid = v;
        sample_in    = 16'(x);
        echo_en      = en;
        delay        = 4'(dly);
        decay_shift  = 2'(ds);
        if (v) begin
            if (m_clr > 0 || cool > 0) m_drop = 1'b1;
            else begin
                exp_q.push_back(model_mix(x, en, dly, ds));
                cool = 3;
            end
        end
        @(posedge clk);
        #1;
        if (cool > 0) cool--;
        if (m_clr > 0) m_clr--;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        echo_en = 1'b0;
        delay = '0;
        decay_shift = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 || busy !== 1'b1 || drop !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: out=%0d valid=%b busy=%b drop=%b required 0 0 1 0", sample_out, sample_out_valid, busy, drop);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            tick(i == 4, 555, 1'b0, 0, 0);
            checks++;
            if (busy !== (i < DEPTH - 1)) begin
                errs++;
                $display("FAIL clear_busy cycle %0d: busy=%b required %b", i + 1, busy, (i < DEPTH - 1));
            end
        end
        idle(4);
        checks++;
        if (drop !== 1'b1 || obs_q.size() != 0) begin
            errs++;
            $display("FAIL clear_drop: drop=%b strobes=%0d required 1 0", drop, obs_q.size());
        end
    endtask

    task automatic test_dry();
        obs_q.delete();
        exp_q.delete();
        tick(1'b1, 'h1234, 1'b0, 5, 1);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 0, 1'b1, 0, 0);
            checks++;
            if (sample_out_valid !== (i == 2)) begin
                errs++;
                $display("FAIL dry_strobe T+%0d: valid=%b required %b", i + 1, sample_out_valid, (i == 2));
            end
            if (i == 2 || i == 9) begin
                checks++;
                if (sample_out !== 16'sh1234) begin
                    errs++;
                    $display("FAIL dry_value T+%0d: out=%h required 1234", i + 1, sample_out);
                end
            end
        end
    endtask

    task automatic test_impulse();
        int imp_exp[10] = '{16000, 0, 0, 8000, 0, 0, 4000, 0, 0, 2000};
        do_reset();
        idle(DEPTH);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, (k == 0) ? 16000 : 0, 1'b1, 3, 0);
            idle(9);
        end
        checks++;
        if (obs_q.size() != 10) begin
            errs++;
            $display("FAIL impulse_count: got %0d required 10", obs_q.size());
        end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] != imp_exp[i]) begin
                errs++;
                $display("FAIL impulse[%0d]: got %0d required %0d", i, obs_q[i], imp_exp[i]);
            end
        end
        // delay=0 wraps the full delay line
        do_reset();
        idle(DEPTH);
        for (int k = 0; k < 17; k++) begin
            tick(1'b1, (k == 0) ? 16000 : 0, 1'b1, 0, 0);
            idle(3);
        end
        checks++;
        if (obs_q.size() != 17 || obs_q[16] != 8000 || obs_q[15] != 0) begin
            errs++;
            $display("FAIL delay0_echo: count=%0d last=%0d required 17 8000", obs_q.size(), (obs_q.size() > 16) ? obs_q[16] : -1);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                errs++;
                $display("FAIL delay0[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int vals[2] = '{30000, -30000};
        int sat_exp[2][2] = '{'{30000, 32767}, '{-30000, -32768}};
        for (int s = 0; s < 2; s++) begin
            do_reset();
            idle(DEPTH);
            for (int k = 0; k < 2; k++) begin
                tick(1'b1, vals[s], 1'b1, 1, 0);
                idle(4);
            end
            checks++;
            if (obs_q.size() != 2) begin
                errs++;
                $display("FAIL sat_count[%0d]: got %0d required 2", s, obs_q.size());
            end
            for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] != sat_exp[s][i]) begin
                    errs++;
                    $display("FAIL sat[%0d][%0d]: got %0d required %0d", s, i, obs_q[i], sat_exp[s][i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        idle(DEPTH);
        checks++;
        if (drop !== 1'b0) begin
            errs++;
            $display("FAIL b2b_drop_pre: drop=%b required 0", drop);
        end
        tick(1'b1, 100, 1'b0, 1, 0);
        tick(1'b1, 200, 1'b0, 1, 0);
        tick(1'b0, 0, 1'b0, 1, 0);
        // Next sample echoes from the previous slot: 100 >>> 1
        tick(1'b1, 0, 1'b1, 1, 0);
        idle(4);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] != 100 || obs_q[1] != 50) begin
            errs++;
            $display("FAIL b2b_outputs: count=%0d first=%0d second=%0d required 2 100 50", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : -1, (obs_q.size() > 1) ? obs_q[1] : -1);
        end
        checks++;
        if (drop !== 1'b1) begin
            errs++;
            $display("FAIL b2b_drop: drop=%b required 1", drop);
        end
    endtask

    task automatic test_random();
        do_reset();
        idle(DEPTH);
        for (int k = 0; k < 80; k++) begin
            tick(1'b1, int'($signed(16'($urandom))), 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 4)));
        end
        idle(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL random_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
                errs++;
                $display("FAIL random[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (drop !== m_drop) begin
            errs++;
            $display("FAIL random_drop: drop=%b required %b", drop, m_drop);
        end
    endtask

    task automatic test_reset_mid_mix();
        do_reset();
        idle(DEPTH);
        tick(1'b1, 16000, 1'b1, 3, 0);
        idle(3);
        tick(1'b1, 0, 1'b1, 3, 0);
        idle(3);
        tick(1'b1, 0, 1'b1, 3, 0);
        tick(1'b0, 0, 1'b1, 3, 0);
        // DUT is now in MIX with a sample in flight
        reset = 1'b1;
        sample_valid = 1'b0;
        #1;
        checks++;
        if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL midreset_state: out=%0d valid=%b busy=%b required 0 0 1", sample_out, sample_out_valid, busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle(DEPTH + 2);
        checks++;
        if (obs_q.size() != 2 || busy !== 1'b0) begin
            errs++;
            $display("FAIL midreset_strobes: count=%0d busy=%b required 2 0", obs_q.size(), busy);
        end
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 0, 1'b1, (k % 4) + 1, 0);
            idle(3);
        end
        checks++;
        if (obs_q.size() != 12) begin
            errs++;
            $display("FAIL midreset_count: got %0d required 12", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] != 0) begin
                errs++;
                $display("FAIL midreset_history[%0d]: got %0d required 0", i, obs_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dry();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid_mix();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
